// File: rtl/heartbeat_monitor.sv
// Heartbeat receiver: measures half periods of an asynchronous square wave and tracks lock/loss.
// Define HEARTBEAT_MONITOR_STICKY_LOST_EN to make o_hb_lost a sticky level cleared by i_lost_clr.
module heartbeat_monitor #(
   parameter int unsigned CLK_FREQ = 100,
   parameter int unsigned HB_FREQ  = 1,
   parameter int unsigned TOL_PCT  = 10,
   parameter int unsigned LOCK_CNT = 4,
   localparam int unsigned HALF_CNT = CLK_FREQ * 1000000 / HB_FREQ / 2,
   localparam int unsigned TOL      = HALF_CNT * TOL_PCT / 100,
   localparam int unsigned MIN_CNT  = HALF_CNT - TOL,
   localparam int unsigned MAX_CNT  = HALF_CNT + TOL,
   localparam int unsigned CW       = $clog2(MAX_CNT + 2)
) (
   input  logic          i_sys_clk,
   input  logic          i_sys_rst,
   input  logic          i_hb,
   input  logic          i_lost_clr,
   output logic          o_hb_alive,
   output logic          o_hb_lost,
   output logic [CW-1:0] o_half_period,
   output logic          o_period_valid,
   output logic [7:0]    o_err_cnt
);

   localparam int unsigned GW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] MinC  = CW'(MIN_CNT);
   localparam logic [CW-1:0] MaxC  = CW'(MAX_CNT);
   localparam logic [GW-1:0] LockC = GW'(LOCK_CNT);

   typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [CW-1:0] cnt_q, meas;
   logic          s1_q, s2_q, s3_q;
   logic          hb_edge, timeout, in_range;
   logic          err_inc, lost_evt;

   logic          alive_q, alive_d;
   logic          lost_q, lost_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] half_q, half_d;
   logic [7:0]    err_q, err_d;

   // Two-flop synchronizer plus a delay flop; either polarity of transition is an edge.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= i_hb;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign hb_edge  = s2_q ^ s3_q;
   assign meas     = cnt_q + CW'(1);
   assign timeout  = (cnt_q == MaxC) && !hb_edge;
   assign in_range = (meas >= MinC) && (meas <= MaxC);

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         cnt_q <= '0;
      end else if (hb_edge) begin
         cnt_q <= '0;
      end else if (cnt_q != MaxC) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q <= StIdle;
         good_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      err_inc  = 1'b0;
      lost_evt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hb_edge) begin
               state_d = StAcq;
               good_d  = '0;
            end
         end
         StAcq: begin
            if (hb_edge) begin
               if (in_range) begin
                  good_d = good_q + GW'(1);
                  if (good_d == LockC) state_d = StLocked;
               end else begin
                  good_d  = '0;
                  err_inc = 1'b1;
               end
            end else if (timeout) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end
         end
         StLocked: begin
            if (hb_edge && !in_range) begin
               state_d  = StAcq;
               good_d   = '0;
               err_inc  = 1'b1;
               lost_evt = 1'b1;
            end else if (timeout) begin
               state_d  = StIdle;
               err_inc  = 1'b1;
               lost_evt = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // First edge out of IDLE has no reference edge, so it is not reported as a measurement.
   always_comb begin
      alive_d = (state_q == StLocked);
      valid_d = hb_edge && (state_q != StIdle);
      half_d  = valid_d ? meas : half_q;
      err_d   = err_q;
      if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
`ifdef HEARTBEAT_MONITOR_STICKY_LOST_EN
      lost_d = lost_q;
      if (i_lost_clr) begin
         lost_d = 1'b0;
         err_d  = err_inc ? 8'd1 : 8'd0;
      end
      if (lost_evt) lost_d = 1'b1;
`else
      lost_d = lost_evt;
`endif
   end

`ifndef HEARTBEAT_MONITOR_STICKY_LOST_EN
   logic unused_lost_clr;
   assign unused_lost_clr = i_lost_clr;
`endif

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         alive_q <= 1'b0;
         lost_q  <= 1'b0;
         valid_q <= 1'b0;
         half_q  <= '0;
         err_q   <= '0;
      end else begin
         alive_q <= alive_d;
         lost_q  <= lost_d;
         valid_q <= valid_d;
         half_q  <= half_d;
         err_q   <= err_d;
      end
   end

   assign o_hb_alive     = alive_q;
   assign o_hb_lost      = lost_q;
   assign o_half_period  = half_q;
   assign o_period_valid = valid_q;
   assign o_err_cnt      = err_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: per-cycle comparison against a time-based model plus directed checks.
// Honours HEARTBEAT_MONITOR_STICKY_LOST_EN the same way the design does.
module tb_heartbeat_monitor;

   localparam int unsigned CLK_FREQ = 1;
   localparam int unsigned HB_FREQ  = 50000;
   localparam int unsigned TOL_PCT  = 20;
   localparam int unsigned LOCK_CNT = 4;
   // HALF = 1e6/50000/2 = 10, TOL = 2, width = clog2(14) = 4
   localparam int MIN_M = 8;
   localparam int MAX_M = 12;

   logic       clk, rst, hb, clr;
   logic       alive, lost, valid;
   logic [3:0] half;
   logic [7:0] err;

   heartbeat_monitor #(
      .CLK_FREQ (CLK_FREQ),
      .HB_FREQ  (HB_FREQ),
      .TOL_PCT  (TOL_PCT),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .i_sys_clk      (clk),
      .i_sys_rst      (rst),
      .i_hb           (hb),
      .i_lost_clr     (clr),
      .o_hb_alive     (alive),
      .o_hb_lost      (lost),
      .o_half_period  (half),
      .o_period_valid (valid),
      .o_err_cnt      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: time is a cycle index; a half period is the distance between edge cycles.
   bit h1, h2, h3, m_edge, m_active, m_locked, lost_ev, err_ev;
   int n, last_edge, run, gap;
   bit exp_alive, exp_lost, exp_valid;
   int exp_half, exp_err;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         {h1, h2, h3} = 3'b000;
         n = 0; last_edge = 0; run = 0;
         m_active = 0; m_locked = 0;
         exp_alive = 0; exp_lost = 0; exp_valid = 0; exp_half = 0; exp_err = 0;
      end else begin
         m_edge = (h2 != h3);
         h3 = h2; h2 = h1; h1 = hb;
         n++;
         gap = n - last_edge;
         exp_alive = m_locked;
         exp_valid = 0; lost_ev = 0; err_ev = 0;
         if (m_edge) begin
            if (m_active) begin
               exp_valid = 1;
               exp_half  = gap;
               if (gap >= MIN_M && gap <= MAX_M) begin
                  if (!m_locked) begin
                     run++;
                     if (run == LOCK_CNT) m_locked = 1;
                  end
               end else begin
                  err_ev = 1; lost_ev = m_locked; m_locked = 0; run = 0;
               end
            end else begin
               m_active = 1; run = 0;
            end
            last_edge = n;
         end else if (m_active && gap == MAX_M + 1) begin
            err_ev = 1; lost_ev = m_locked; m_locked = 0; m_active = 0;
         end
`ifdef HEARTBEAT_MONITOR_STICKY_LOST_EN
         if (clr) begin
            exp_err = 0; exp_lost = 0;
         end
         if (lost_ev) exp_lost = 1;
`else
         exp_lost = lost_ev;
`endif
         if (err_ev && exp_err < 255) exp_err++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("alive", alive, exp_alive);
         check("lost",  lost,  exp_lost);
         check("valid", valid, exp_valid);
         check("half",  half,  exp_half);
         check("err",   err,   exp_err);
      end
   end

   int lost_seen = 0;
   initial forever begin
      @(negedge clk);
      if (!rst && lost) lost_seen++;
   end

   bit rand_phase = 0;
`ifdef HEARTBEAT_MONITOR_STICKY_LOST_EN
   initial forever begin
      @(posedge clk);
      #2;
      if (rand_phase) clr = ($urandom_range(0, 7) == 0);
   end
`endif

   // Each toggle lands 2 time units after a posedge, so spacing is exactly `cycles` clocks.
   task automatic toggle_after(input int cycles);
      repeat (cycles) @(posedge clk);
      #2 hb = ~hb;
   endtask

   // Six posedges past the last toggle, then mid-cycle: outputs have settled.
   task automatic settle6;
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic lock_up;
      repeat (6) toggle_after(10);
   endtask

   int base_lost;

   initial begin
      hb = 0; clr = 0; rst = 1;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      @(negedge clk); #1;
      check("reset_alive", alive, 0);
      check("reset_err", err, 0);
      check("reset_half", half, 0);

      // Lock at nominal rate
      lock_up();
      settle6();
      check("lock_alive", alive, 1);
      check("lock_half", half, 10);
      check("lock_err", err, 0);

      // Tolerance boundaries: 8 and 12 hold lock, 7 and 13 break it
      toggle_after(4);
      toggle_after(8);
      toggle_after(12);
      settle6();
      check("tol12_alive", alive, 1);
      check("tol12_half", half, 12);
      check("tol12_err", err, 0);
      toggle_after(1);
      settle6();
      check("tol7_alive", alive, 0);
      check("tol7_err", err, 1);
      check("tol7_half", half, 7);
`ifndef HEARTBEAT_MONITOR_STICKY_LOST_EN
      check("tol7_pulses", lost_seen, 1);
`else
      check("tol7_sticky", lost, 1);
`endif
      toggle_after(4);
      repeat (3) toggle_after(10);
      settle6();
      check("relock_alive", alive, 1);
      toggle_after(7);
      settle6();
      check("tol13_alive", alive, 0);
      check("tol13_err", err, 2);
      check("tol13_half", half, 13);

      // Timeout while locked, then hold
      toggle_after(4);
      repeat (3) toggle_after(10);
      settle6();
      check("prelost_alive", alive, 1);
      base_lost = lost_seen;
      repeat (40) @(posedge clk);
      @(negedge clk); #1;
      check("timeout_alive", alive, 0);
      check("timeout_err", err, 3);
`ifndef HEARTBEAT_MONITOR_STICKY_LOST_EN
      check("timeout_pulses", lost_seen - base_lost, 1);
`endif

      // Saturation of the error counter
      repeat (300) toggle_after(5);
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      check("sat_err", err, 255);

      // Async reset between edges while locked
      lock_up();
      repeat (4) @(posedge clk);
      #3 rst = 1;
      #1;
      check("rst_alive", alive, 0);
      check("rst_lost", lost, 0);
      check("rst_valid", valid, 0);
      check("rst_half", half, 0);
      check("rst_err", err, 0);
      base_lost = lost_seen;
      hb = 0;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      repeat (4) toggle_after(10);
      settle6();
      check("relock4_alive", alive, 0);
      toggle_after(4);
      settle6();
      check("relock5_alive", alive, 1);
      check("rst_nopulse", lost_seen - base_lost, 0);

      // Randomized half periods, mostly near nominal
      rand_phase = 1;
      for (int i = 0; i < 250; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 70)      toggle_after($urandom_range(MIN_M, MAX_M));
         else if (r < 90) toggle_after($urandom_range(3, 16));
         else             toggle_after($urandom_range(13, 30));
      end
      rand_phase = 0;
      clr = 0;
      repeat (20) @(posedge clk);

`ifdef HEARTBEAT_MONITOR_STICKY_LOST_EN
      // Lost event coinciding with clear keeps the flag set; a later clear drops it
      lock_up();
      @(posedge clk); #2 clr = 1;
      @(posedge clk); #2 clr = 0;
      @(negedge clk); #1;
      check("sticky_cleared", lost, 0);
      check("sticky_err0", err, 0);
      for (int i = 0; i < 40; i++) begin
         if (m_locked && (n - last_edge) == MAX_M) break;
         @(posedge clk); #2;
      end
      clr = 1;
      @(posedge clk); #2 clr = 0;
      @(negedge clk); #1;
      check("sticky_coincide", lost, 1);
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check("sticky_held", lost, 1);
      @(posedge clk); #2 clr = 1;
      @(posedge clk); #2 clr = 0;
      @(negedge clk); #1;
      check("sticky_clr_lost", lost, 0);
      check("sticky_clr_err", err, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
